conv_window_fetch: RTL and testbench
====================================

Name: conv_window_fetch

Overview:
- Downstream consumer of the image memory's read port A.
- Walks a stored image and fetches every valid (unpadded) 3x3 window, one 18-bit tap per cycle.
- Presents each complete window, with its coordinates, to the convolution engine over a valid/ready handshake.
- One memory read per cycle; no line buffering. Throughput is 11 cycles per window when the sink is always ready.

Parameters:
- IMG_W, 32, image width in pixels; legal range 3..256.
- IMG_H, 32, image height in pixels; legal range 3..256.
- BASE_ADDR, 0, word address of pixel (0,0); BASE_ADDR + IMG_W*IMG_H must be <= 2^21.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a full-image pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window handshakes.
- mem_addr  out  21  read address to memory port A.
- mem_data  in  18  read data from memory port A; 1-cycle registered latency.
- win_data  out  162  9 taps, row-major; tap k occupies bits [18k+17:18k]; tap 0 is top-left.
- win_x  out  8  column of the window's top-left pixel.
- win_y  out  8  row of the window's top-left pixel.
- win_valid  out  1  window valid.
- win_ready  in  1  sink accepts the window.

Behaviour:
- Clock is clk. Reset is synchronous, active-low, on rst_n.
- Reset state is IDLE.
  - busy, done, win_valid, win_data, win_x, win_y, tap counter and window coordinates all reset to 0.
  - Reset asserted in any state aborts the pass; no done pulse is produced.
- Addressing: tap t (r = t/3, c = t%3) of window (x,y) has address BASE_ADDR + (y+r)*IMG_W + (x+c). All arithmetic is 21-bit unsigned.
- mem_addr is combinational from state and counters:
  - In FETCH, mem_addr is the address of the current tap t.
  - In all other states, mem_addr = BASE_ADDR.
- Memory timing: mem_data in a given cycle carries the data for the address driven in the previous cycle.
- FSM states: IDLE, FETCH, DRAIN, PRESENT, FIN.
  - IDLE: when start=1, go to FETCH with x=0, y=0, t=0.
  - FETCH: drive the address for tap t. If t>=1, capture mem_data into tap t-1. When t=8, go to DRAIN; otherwise t++.
  - DRAIN: capture mem_data into tap 8. Load win_x=x and win_y=y. Go to PRESENT.
  - PRESENT: win_valid=1. win_data, win_x and win_y are held stable until win_valid && win_ready.
  - On handshake:
    - If x = IMG_W-3 and y = IMG_H-3, go to FIN.
    - Else if x = IMG_W-3, set x=0, y++, t=0 and go to FETCH.
    - Else x++, t=0, go to FETCH.
  - win_valid deasserts in the cycle after the handshake.
  - FIN: done=1 for exactly one cycle, then IDLE. busy=1 in FIN.
- Latency: if start is sampled at edge E0, the first window has win_valid=1 in the cycle after edge E0+10.
  - With win_ready held high, windows appear every 11 cycles.
- Window count per pass is (IMG_W-2)*(IMG_H-2), scanned row-major.
- start while busy=1 is ignored and not queued. start in the FIN cycle is ignored.
- win_ready while win_valid=0 has no effect.
- win_data keeps the last window's value after win_valid drops.
- A 3x3 image produces exactly one window, then done.

Test Plan:
- Memory word i holds i*10; IMG_W=5, IMG_H=4, BASE_ADDR=0; win_ready=1; pulse start.
  -> First window win_x=0, win_y=0, taps 0,10,20,50,60,70,100,110,120.
  -> win_valid first seen in the cycle after E0+10.
- Same setup, run to completion.
  -> Exactly 6 windows, coordinates (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  -> Last window taps 70,80,90,120,130,140,170,180,190.
  -> done pulses for 1 cycle, then busy=0.
- Backpressure: hold win_ready=0 for 20 cycles on window 2.
  -> win_valid and win_data stable throughout; no address activity (mem_addr=BASE_ADDR).
  -> Sequence resumes correctly after win_ready rises.
- BASE_ADDR=1000, IMG_W=IMG_H=3.
  -> mem_addr sequence 1000,1001,1002,1003,1004,1005,1006,1007,1008.
  -> One window, then done.
- Pulse start again during window 3.
  -> Ignored; total window count unchanged.
- Assert rst_n=0 for 1 cycle mid-FETCH of window 4.
  -> Next cycle all outputs are 0 and the state is IDLE; no done pulse.
  -> A fresh start restarts from (0,0).

Source files
------------

// File: rtl/conv_window_fetch.sv
// Walks a stored image through memory read port A and fetches every unpadded 3x3
// window, one tap per cycle, handing each window to the convolution engine.
module conv_window_fetch #(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [20:0]  mem_addr,
  input  logic [17:0]  mem_data,
  output logic [161:0] win_data,
  output logic [7:0]   win_x,
  output logic [7:0]   win_y,
  output logic         win_valid,
  input  logic         win_ready
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, FIN} state_t;

  localparam logic [7:0]  X_LAST = 8'(IMG_W - 3);
  localparam logic [7:0]  Y_LAST = 8'(IMG_H - 3);
  localparam logic [20:0] BASE   = 21'(BASE_ADDR);
  localparam logic [20:0] WIDTH  = 21'(IMG_W);

  state_t         state_q, state_d;
  logic [7:0]     x_q, x_d, y_q, y_d;
  logic [3:0]     t_q, t_d;
  logic [17:0]    taps_q [0:7];
  logic [161:0]   win_data_q, win_next;
  logic [7:0]     win_x_q, win_y_q;
  logic [3:0]     tap_r, tap_c;
  logic [2:0]     cap_idx;
  logic [20:0]    tap_addr;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          x_d     = 8'd0;
          y_d     = 8'd0;
          t_d     = 4'd0;
        end
      end
      FETCH: begin
        if (t_q == 4'd8) state_d = DRAIN;
        else             t_d     = t_q + 4'd1;
      end
      DRAIN:   state_d = PRESENT;
      PRESENT: begin
        if (win_ready) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = FIN;
          end else begin
            state_d = FETCH;
            t_d     = 4'd0;
            if (x_q == X_LAST) begin
              x_d = 8'd0;
              y_d = y_q + 8'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      t_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t_q     <= t_d;
    end
  end

  // Tap row/column of the address being driven; data for it arrives a cycle later.
  always_comb begin
    tap_r    = t_q / 4'd3;
    tap_c    = t_q % 4'd3;
    tap_addr = BASE + (21'(y_q) + 21'(tap_r)) * WIDTH + 21'(x_q) + 21'(tap_c);
    mem_addr = (state_q == FETCH) ? tap_addr : BASE;
    cap_idx  = 3'(t_q - 4'd1);
  end

  always_ff @(posedge clk) begin
    if (state_q == FETCH && t_q != 4'd0) taps_q[cap_idx] <= mem_data;
  end

  always_comb begin
    win_next = '0;
    for (int k = 0; k < 8; k++) win_next[18*k +: 18] = taps_q[k];
    win_next[161:144] = mem_data;
  end

  // Output window is a separate copy so it survives the next window's fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_data_q <= '0;
      win_x_q    <= 8'd0;
      win_y_q    <= 8'd0;
    end else if (state_q == DRAIN) begin
      win_data_q <= win_next;
      win_x_q    <= x_q;
      win_y_q    <= y_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign win_valid = (state_q == PRESENT);
  assign win_data  = win_data_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch: a 5x4 image at base 0 and a 3x3 image at
// base 1000, each fed by a one-cycle-latency memory holding word i = i*10.
module tb_conv_window_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start_a, busy_a, done_a, win_valid_a, win_ready_a;
  logic [20:0]  mem_addr_a;
  logic [17:0]  mem_data_a;
  logic [161:0] win_data_a;
  logic [7:0]   win_x_a, win_y_a;

  logic         start_b, busy_b, done_b, win_valid_b, win_ready_b;
  logic [20:0]  mem_addr_b;
  logic [17:0]  mem_data_b;
  logic [161:0] win_data_b;
  logic [7:0]   win_x_b, win_y_b;

  int vectors = 0;
  int miscompares = 0;

  conv_window_fetch #(.IMG_W(5), .IMG_H(4), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .win_data(win_data_a),
    .win_x(win_x_a), .win_y(win_y_a), .win_valid(win_valid_a), .win_ready(win_ready_a)
  );

  conv_window_fetch #(.IMG_W(3), .IMG_H(3), .BASE_ADDR(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .win_data(win_data_b),
    .win_x(win_x_b), .win_y(win_y_b), .win_valid(win_valid_b), .win_ready(win_ready_b)
  );

  always_ff @(posedge clk) begin
    mem_data_a <= 18'(int'(mem_addr_a) * 10);
    mem_data_b <= 18'(int'(mem_addr_b) * 10);
  end

  task automatic chk(input string tag, input logic [161:0] obs, input logic [161:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [161:0] win_exp(input int w, input int base, input int x, input int y);
    logic [161:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[18*k +: 18] = 18'((base + (y + k/3) * w + x + k%3) * 10);
    return v;
  endfunction

  task automatic wait_valid(input bit sel_b, input string tag);
    int n;
    n = 0;
    while (((sel_b ? win_valid_b : win_valid_a) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrive"}, sel_b ? win_valid_b : win_valid_a, 1);
  endtask

  task automatic check_win_a(input int w);
    string tag;
    tag = $sformatf("winA%0d", w);
    chk({tag, "_x"}, win_x_a, w % 3);
    chk({tag, "_y"}, win_y_a, w / 3);
    chk({tag, "_data"}, win_data_a, win_exp(5, 0, w % 3, w / 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [161:0] first_win, last_win, held;
    int extra;

    first_win = {18'd120, 18'd110, 18'd100, 18'd70, 18'd60, 18'd50, 18'd20, 18'd10, 18'd0};
    last_win  = {18'd190, 18'd180, 18'd170, 18'd140, 18'd130, 18'd120, 18'd90, 18'd80, 18'd70};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; win_ready_a = 1'b1; win_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid", win_valid_a, 0);
    chk("rst_data", win_data_a, 0);
    chk("rst_xy", {win_x_a, win_y_a}, 0);
    chk("rst_addr", mem_addr_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass 1: latency, address walk, backpressure, ignored start, completion
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("p1_busy", busy_a, 1);
    chk("p1_addr0", mem_addr_a, 0);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("p1_addr%0d", i), mem_addr_a, (i / 3) * 5 + i % 3);
    end
    @(negedge clk);
    chk("p1_valid_e9", win_valid_a, 0);
    @(negedge clk);
    chk("p1_valid_e10", win_valid_a, 1);
    chk("p1_first_taps", win_data_a, first_win);
    check_win_a(0);
    @(negedge clk);
    chk("p1_valid_drop", win_valid_a, 0);
    chk("p1_data_keep", win_data_a, first_win);
    win_ready_a = 1'b0;

    wait_valid(1'b0, "w1");
    check_win_a(1);
    held = win_data_a;
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", win_valid_a, 1);
      chk("bp_data", win_data_a, held);
      chk("bp_x", win_x_a, 1);
      chk("bp_addr", mem_addr_a, 0);
      @(negedge clk);
    end
    win_ready_a = 1'b1;
    @(negedge clk);

    for (int w = 2; w < 6; w++) begin
      wait_valid(1'b0, $sformatf("w%0d", w));
      check_win_a(w);
      if (w == 5) chk("p1_last_taps", win_data_a, last_win);
      if (w == 2) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("p1_done", done_a, 1);
    chk("p1_busy_fin", busy_a, 1);
    @(negedge clk);
    chk("p1_done_pulse", done_a, 0);
    chk("p1_busy_end", busy_a, 0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (win_valid_a || busy_a || done_a) extra++;
    end
    chk("p1_no_extra", extra, 0);

    // Pass 2: reset mid-fetch of the fourth window, then restart
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int w = 0; w < 3; w++) begin
      wait_valid(1'b0, $sformatf("r%0d", w));
      check_win_a(w);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("r_busy", busy_a, 0);
    chk("r_done", done_a, 0);
    chk("r_valid", win_valid_a, 0);
    chk("r_data", win_data_a, 0);
    chk("r_xy", {win_x_a, win_y_a}, 0);
    chk("r_addr", mem_addr_a, 0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy_a || done_a || win_valid_a) extra++;
    end
    chk("r_quiet", extra, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_valid(1'b0, "rs0");
    chk("rs_first_taps", win_data_a, first_win);
    check_win_a(0);

    // Pass 3: 3x3 image at base 1000
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_addr0", mem_addr_b, 1000);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("b_addr%0d", i), mem_addr_b, 1000 + i);
    end
    wait_valid(1'b1, "b0");
    chk("b_xy", {win_x_b, win_y_b}, 0);
    chk("b_data", win_data_b, win_exp(3, 1000, 0, 0));
    @(negedge clk);
    chk("b_done", done_b, 1);
    chk("b_valid_drop", win_valid_b, 0);
    @(negedge clk);
    chk("b_done_pulse", done_b, 0);
    chk("b_busy_end", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
